// File: rtl/fpmulr2_pkg.sv
// Shared FPU multiply definitions: default significand width, product width, lzcnt type.
// Used by fpmulr2 and the reusable fpmul_clz leading-zero counter.
package fpmulr2_pkg;

    localparam int FPWID_DEF = 112;

    typedef logic [7:0] lzcnt_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/fpmul_clz.sv
// Combinational leading-zero counter; an all-zero input yields W.
// Shared by the multiplier result register and the normalise stage.
module fpmul_clz
    import fpmulr2_pkg::*;
#(
    parameter int W = 224
) (
    input  logic [W-1:0] x,
    output lzcnt_t       cnt
);

    logic hit;

    always_comb begin
        hit = 1'b0;
        cnt = lzcnt_t'(W);
        for (int i = W - 1; i >= 0; i--) begin
            if (!hit && x[i]) begin
                hit = 1'b1;
                cnt = lzcnt_t'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpmulr2.sv
// Iterative radix-2 shift-add significand multiplier with registered lzcnt.
// Define FPMUL_EARLY_EXIT_EN to skip trailing all-zero multiplier bits in one edge.
module fpmulr2
    import fpmulr2_pkg::*;
#(
    parameter int FPWID = FPWID_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld,
    input  logic [FPWID-1:0]      a,
    input  logic [FPWID-1:0]      b,
    output logic [2*FPWID-1:0]    p,
    output logic                  done,
    output logic                  busy,
    output logic [7:0]            lzcnt
);

    localparam int PW = prod_w(FPWID);

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [FPWID-1:0]   mcand_q, mcand_d;
    logic [FPWID-1:0]   acc_q, acc_d;
    logic [FPWID-1:0]   mplr_q, mplr_d;
    logic [PW-1:0]      p_q, p_d;
    lzcnt_t             lz_q, lz_d;
    logic               done_q, done_d;

    logic [FPWID:0]     sum;
    logic [PW-1:0]      step;
    logic [PW-1:0]      prod;
    lzcnt_t             clz_out;
    logic               run_it;
    logic               finish;

    assign prod   = {acc_q, mplr_q};
    assign run_it = (state_q == S_RUN) && (cnt_q != 8'd0);
    assign finish = (state_q == S_RUN) && (cnt_q == 8'd0);

    fpmul_clz #(
        .W (PW)
    ) u_clz (
        .x   (prod),
        .cnt (clz_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ld) begin
            state_d = S_RUN;
        end else if (finish) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        busy  = (state_q == S_RUN);
        done  = done_q;
        p     = p_q;
        lzcnt = lz_q;
    end

`ifdef FPMUL_EARLY_EXIT_EN
    logic [FPWID-1:0] low_mask;

    always_comb begin
        for (int i = 0; i < FPWID; i++) begin
            low_mask[i] = (i < int'(cnt_q));
        end
    end
`endif

    // Carry out of the add lands in sum[FPWID] and shifts into acc.
    always_comb begin
        sum  = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        step = {sum, mplr_q[FPWID-1:1]};

        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        lz_d    = lz_q;
        done_d  = finish && !ld;

        if (ld) begin
            mcand_d = a;
            acc_d   = '0;
            mplr_d  = b;
            cnt_d   = 8'(FPWID);
        end else if (run_it) begin
`ifdef FPMUL_EARLY_EXIT_EN
            if ((mplr_q & low_mask) == '0) begin
                {acc_d, mplr_d} = prod >> cnt_q;
                cnt_d           = 8'd0;
            end else begin
                {acc_d, mplr_d} = step;
                cnt_d           = cnt_q - 8'd1;
            end
`else
            {acc_d, mplr_d} = step;
            cnt_d           = cnt_q - 8'd1;
`endif
        end

        if (finish && !ld) begin
            p_d  = prod;
            lz_d = clz_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            p_q     <= '0;
            lz_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            p_q     <= p_d;
            lz_q    <= lz_d;
            done_q  <= done_d;
        end
    end

endmodule
